// File: rtl/button_conditioner.sv
// Per-channel push-button front end: two-flop synchroniser, counting debouncer,
// registered press/release events and a long-press (hold) timer.
// Every output is a register, so no raw pin reaches an output combinationally.
module button_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int HOLD_CYCLES     = 300_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_hold,
    output logic [N_BTN-1:0] btn_hold_pls
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    // Last count value before the debounced level flips / the hold flag sets.
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_REL  = 2'd0,
        ST_ARM  = 2'd1,
        ST_HELD = 2'd2
    } hold_state_e;

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;

    // Two-flop synchroniser for the asynchronous pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
        logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
        logic              level_q, level_d;
        logic              rise_d, fall_d;
        logic              press_q, release_q;
        hold_state_e       state_q, state_d;
        logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
        logic              hold_q, hold_d;
        logic              hold_pls_q, hold_pls_d;

        // Debounce: flip the level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
        always_comb begin
            db_cnt_d = '0;
            level_d  = level_q;
            if (sync2_q[gi] != level_q) begin
                if (db_cnt_q == DB_LAST) begin
                    level_d  = sync2_q[gi];
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
        end

        // Level edges are known in the same cycle the level register is loaded.
        assign rise_d = level_d & ~level_q;
        assign fall_d = ~level_d & level_q;

        // Hold timer next state; a release always takes priority over hold expiry.
        always_comb begin
            state_d    = state_q;
            hold_cnt_d = hold_cnt_q;
            hold_d     = hold_q;
            hold_pls_d = 1'b0;
            case (state_q)
                ST_REL: begin
                    hold_cnt_d = '0;
                    hold_d     = 1'b0;
                    if (rise_d) begin
                        state_d = ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (fall_d) begin
                        state_d    = ST_REL;
                        hold_cnt_d = '0;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_d    = ST_HELD;
                        hold_d     = 1'b1;
                        hold_pls_d = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (fall_d) begin
                        state_d    = ST_REL;
                        hold_cnt_d = '0;
                        hold_d     = 1'b0;
                    end
                end
                default: begin
                    state_d    = ST_REL;
                    hold_cnt_d = '0;
                    hold_d     = 1'b0;
                end
            endcase
        end

        // Channel state registers and registered event pulses.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                db_cnt_q   <= '0;
                level_q    <= 1'b0;
                press_q    <= 1'b0;
                release_q  <= 1'b0;
                state_q    <= ST_REL;
                hold_cnt_q <= '0;
                hold_q     <= 1'b0;
                hold_pls_q <= 1'b0;
            end else begin
                db_cnt_q   <= db_cnt_d;
                level_q    <= level_d;
                press_q    <= rise_d;
                release_q  <= fall_d;
                state_q    <= state_d;
                hold_cnt_q <= hold_cnt_d;
                hold_q     <= hold_d;
                hold_pls_q <= hold_pls_d;
            end
        end

        assign btn_level[gi]    = level_q;
        assign btn_press[gi]    = press_q;
        assign btn_release[gi]  = release_q;
        assign btn_hold[gi]     = hold_q;
        assign btn_hold_pls[gi] = hold_pls_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus randomized per-channel
// press patterns, checked every cycle against a history-based reference model.
module tb_button_conditioner;

    localparam int N = 5;
    localparam int D = 4;
    localparam int H = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_hold, btn_hold_pls;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BTN(N), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .btn_hold(btn_hold), .btn_hold_pls(btn_hold_pls)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: raw pin history since reset release, plus per-channel facts.
    logic [N-1:0] raw_hist[$];
    int           n_edge;
    int           last_flip[N];
    int           press_edge[N];
    logic [N-1:0] e_level, e_press, e_rel, e_hold, e_hpls;

    task automatic model_reset();
        raw_hist.delete();
        n_edge  = 0;
        e_level = '0; e_press = '0; e_rel = '0; e_hold = '0; e_hpls = '0;
        for (int c = 0; c < N; c++) begin
            last_flip[c]  = 0;
            press_edge[c] = 0;
        end
    endtask

    // Synchronised value seen at edge k is the pin value driven before edge k-2.
    function automatic logic [N-1:0] s_at(input int k);
        if (k - 2 >= 1) return raw_hist[k - 3];
        return '0;
    endfunction

    task automatic model_edge(input logic [N-1:0] raw);
        logic [N-1:0] sk;
        logic         flip, new_hold;
        raw_hist.push_back(raw);
        n_edge++;
        e_press = '0; e_rel = '0; e_hpls = '0;
        for (int c = 0; c < N; c++) begin
            // Flip when the whole last-D window since the previous flip disagrees with the level.
            flip = 1'b1;
            if (n_edge - D + 1 <= last_flip[c]) flip = 1'b0;
            for (int k = n_edge - D + 1; k <= n_edge; k++) begin
                sk = s_at(k);
                if (sk[c] == e_level[c]) flip = 1'b0;
            end
            if (flip) begin
                if (e_level[c]) e_rel[c] = 1'b1;
                else begin
                    e_press[c]    = 1'b1;
                    press_edge[c] = n_edge;
                end
                e_level[c]   = ~e_level[c];
                last_flip[c] = n_edge;
            end
            new_hold  = e_level[c] && (n_edge - press_edge[c] >= H);
            e_hpls[c] = new_hold && !e_hold[c];
            e_hold[c] = new_hold;
        end
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge.
    task automatic step(input logic [N-1:0] raw);
        btn_raw = raw;
        @(posedge clk);
        cyc++;
        if (!rst) model_edge(raw);
        @(negedge clk);
        check_eq("level",    btn_level,    e_level);
        check_eq("press",    btn_press,    e_press);
        check_eq("release",  btn_release,  e_rel);
        check_eq("hold",     btn_hold,     e_hold);
        check_eq("hold_pls", btn_hold_pls, e_hpls);
    endtask

    // Asynchronous reset from a negedge: outputs must clear before any clock edge.
    task automatic do_reset(input int cycles);
        rst = 1'b1;
        #1;
        check_eq("rst_async", {btn_level, btn_press, btn_release, btn_hold, btn_hold_pls}, '0);
        model_reset();
        repeat (cycles) step(btn_raw);
        rst = 1'b0;
    endtask

    logic [N-1:0] cur;
    int           seg_left[N];
    int           lat, press_at, hpls_at, hpls_cnt;
    logic         seen;

    initial begin
        model_reset();
        rst     = 1'b1;
        btn_raw = '1;
        cur     = '0;
        @(negedge clk);
        // 1: reset held with every pin pressed
        repeat (4) step('1);
        rst = 1'b0;
        repeat (3) step('0);

        // 2: channel 0 press latency
        cur = 5'b00001;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            step(cur);
            if (btn_press[0] && lat < 0) lat = i;
        end
        check_eq("press_latency", lat, 6);
        cur = '0;
        repeat (8) step(cur);

        // 3: channel 1 glitches shorter than the debounce window
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cur[1] = (i < 3) || (i >= 4 && i < 7);
            step(cur);
            seen = seen | btn_level[1] | btn_press[1];
        end
        check_eq("glitch_ignored", seen, 0);

        // 4: channel 2 long press, hold pulse timing, release drops hold
        cur = 5'b00100;
        press_at = -1; hpls_at = -1; hpls_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step(cur);
            if (btn_press[2] && press_at < 0) press_at = cyc;
            if (btn_hold_pls[2]) begin
                hpls_cnt++;
                if (hpls_at < 0) hpls_at = cyc;
            end
            if (press_at >= 0 && cyc - press_at >= 20) break;
        end
        check_eq("hold_delay", hpls_at - press_at, 10);
        check_eq("hold_pls_once", hpls_cnt, 1);
        check_eq("hold_still_high", btn_hold[2], 1);
        cur = '0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(cur);
            if (btn_release[2]) begin
                seen = 1'b1;
                check_eq("hold_drop_with_release", btn_hold[2], 0);
            end
        end
        check_eq("release_seen", seen, 1);
        repeat (4) step(cur);

        // 5: channel 3 short press, no hold events
        cur = 5'b01000;
        hpls_cnt = 0;
        for (int i = 0; i < 20 && !btn_level[3]; i++) step(cur);
        repeat (4) step(cur);
        cur = '0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(cur);
            seen = seen | btn_release[3];
            if (btn_hold[3] | btn_hold_pls[3]) hpls_cnt++;
        end
        check_eq("short_release", seen, 1);
        check_eq("short_no_hold", hpls_cnt, 0);

        // 6: reset mid-hold on channel 2 with the button kept down
        cur = 5'b00100;
        for (int i = 0; i < 20 && !btn_press[2]; i++) step(cur);
        repeat (6) step(cur);
        check_eq("pre_reset_level", btn_level[2], 1);
        do_reset(3);
        lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            step(cur);
            if (btn_press[2]) lat = i;
        end
        check_eq("repress_latency", lat, 6);
        hpls_at = -1;
        for (int i = 1; i <= 20 && hpls_at < 0; i++) begin
            step(cur);
            if (btn_hold_pls[2]) hpls_at = i;
        end
        check_eq("rehold_delay", hpls_at, 10);
        cur = '0;
        repeat (10) step(cur);

        // Random: per-channel segments of random length, occasional reset
        for (int c = 0; c < N; c++) seg_left[c] = 0;
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < N; c++) begin
                if (seg_left[c] == 0) begin
                    cur[c] = ~cur[c];
                    seg_left[c] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 5)
                                                              : $urandom_range(6, 30);
                end
                seg_left[c]--;
            end
            if ($urandom_range(0, 399) == 0) begin
                btn_raw = cur;
                do_reset($urandom_range(2, 4));
            end else begin
                step(cur);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
